// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared widths, state encoding and arbitration helper
// Rev 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;
    localparam int STATE_W = 3;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } arb_state_e;

    // D wins when it is alone, or on a tie when I was served last.
    function automatic logic arb_pick_d(input logic req_i, input logic req_d, input logic last);
        return req_d & (~req_i | (last == LAST_I));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_fsm.sv
`default_nettype none
// ============================================================================
// mem_arb_fsm : arbitration state, last-granted side and abandon tracking
// Rev 1.0
// ============================================================================
module mem_arb_fsm
    import mem_arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_req_i,
    input  logic               d_req_i,
    input  logic               mem_busy_i,
    output logic [STATE_W-1:0] state_o,
    output logic               take_i_o,
    output logic               take_d_o,
    output logic               accept_i_o,
    output logic               accept_d_o
);

    arb_state_e state_q;
    logic       last_q;
    logic       abandon_q;

    logic w_idle;
    logic w_grant_i;
    logic w_in_grant;
    logic w_take_i;
    logic w_take_d;
    logic w_owner_req;
    logic w_finish;
    logic w_keep;

    always_comb begin
        w_idle      = (state_q == IDLE);
        w_grant_i   = (state_q == GRANT_I);
        w_in_grant  = (state_q == GRANT_I) | (state_q == GRANT_D);
        w_take_d    = w_idle & arb_pick_d(i_req_i, d_req_i, last_q);
        w_take_i    = w_idle & i_req_i & ~w_take_d;
        w_owner_req = w_grant_i ? i_req_i : d_req_i;
        w_finish    = w_in_grant & ~mem_busy_i;
        // A requester that let go at any point during its grant loses the result.
        w_keep      = w_finish & w_owner_req & ~abandon_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= LAST_I;
            abandon_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    abandon_q <= 1'b0;
                    if (w_take_d) begin
                        state_q <= GRANT_D;
                        last_q  <= LAST_D;
                    end else if (w_take_i) begin
                        state_q <= GRANT_I;
                        last_q  <= LAST_I;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (w_finish) begin
                        abandon_q <= 1'b0;
                        if (!w_keep) begin
                            state_q <= IDLE;
                        end else if (w_grant_i) begin
                            state_q <= DONE_I;
                        end else begin
                            state_q <= DONE_D;
                        end
                    end else if (!w_owner_req) begin
                        abandon_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state_o    = state_q;
    assign take_i_o   = w_take_i;
    assign take_d_o   = w_take_d;
    assign accept_i_o = w_keep & w_grant_i;
    assign accept_d_o = w_keep & ~w_grant_i;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter sharing one memory port between I and D caches
// Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    logic [STATE_W-1:0] w_state;
    logic               w_d_req;
    logic               w_take_i;
    logic               w_take_d;
    logic               w_accept_i;
    logic               w_accept_d;
    logic               w_granted;

    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [BLOCK_W-1:0] wdata_q,   wdata_d;
    logic               rd_q,      rd_d;
    logic               wr_q,      wr_d;
    logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;

    assign w_d_req = D_READ | D_WRITE;

    mem_arb_fsm u_fsm (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .i_req_i    (I_READ),
        .d_req_i    (w_d_req),
        .mem_busy_i (MEM_BUSYWAIT),
        .state_o    (w_state),
        .take_i_o   (w_take_i),
        .take_d_o   (w_take_d),
        .accept_i_o (w_accept_i),
        .accept_d_o (w_accept_d)
    );

    // The request is captured at grant so the memory port stays stable even
    // if the requester changes or drops its inputs mid-transaction.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        if (w_take_d) begin
            addr_d  = D_ADDRESS;
            wdata_d = D_WRITEDATA;
            rd_d    = D_READ & ~D_WRITE;
            wr_d    = D_WRITE;
        end else if (w_take_i) begin
            addr_d  = I_ADDRESS;
            wdata_d = '0;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
        end
        i_rdata_d = w_accept_i ? MEM_READDATA : i_rdata_q;
        d_rdata_d = w_accept_d ? MEM_READDATA : d_rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign w_granted     = (w_state == GRANT_I) | (w_state == GRANT_D);
    assign MEM_READ      = w_granted & rd_q;
    assign MEM_WRITE     = w_granted & wr_q;
    assign MEM_ADDRESS   = w_granted ? addr_q  : '0;
    assign MEM_WRITEDATA = w_granted ? wdata_q : '0;

    assign I_BUSYWAIT = I_READ  & (w_state != DONE_I);
    assign D_BUSYWAIT = w_d_req & (w_state != DONE_D);
    assign I_READDATA = i_rdata_q;
    assign D_READDATA = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed vectors, corner sequences and random traffic vs model
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         I_READ;
    logic [27:0]  I_ADDRESS;
    logic [127:0] I_READDATA;
    logic         I_BUSYWAIT;
    logic         D_READ;
    logic         D_WRITE;
    logic [27:0]  D_ADDRESS;
    logic [127:0] D_WRITEDATA;
    logic [127:0] D_READDATA;
    logic         D_BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    mem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for 'lat' cycles of an active request, then completes.
    logic         mem_rand = 1'b0;
    int           dir_lat  = 0;
    logic [127:0] dir_data = '0;
    int           rnd_lat  = 1;
    logic [127:0] rnd_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    int           mem_cnt  = 0;
    logic         w_mem_req;
    int           cur_lat;

    assign w_mem_req    = MEM_READ | MEM_WRITE;
    assign cur_lat      = mem_rand ? rnd_lat : dir_lat;
    assign MEM_BUSYWAIT = w_mem_req && (mem_cnt != cur_lat);
    assign MEM_READDATA = mem_rand ? rnd_data : dir_data;

    always @(posedge CLK) begin
        if (w_mem_req && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
        else                           mem_cnt <= 0;
        if (w_mem_req && !MEM_BUSYWAIT) begin
            rnd_lat  <= $urandom_range(0, 3);
            rnd_data <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    typedef struct {
        logic         i_rd;
        logic         d_rd;
        logic         d_wr;
        logic [27:0]  i_addr;
        logic [27:0]  d_addr;
        logic [127:0] d_wdata;
        logic [127:0] mdata;
        int           lat;
        logic         exp_d;
        logic         exp_rd;
        logic         exp_wr;
        logic [27:0]  exp_addr;
        logic [127:0] exp_wdata;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[5];

    // Directed-sequence scratch
    int   ng, dlow, ncyc, gap;
    logic pm, seen_i, side_d, done;

    // Random-phase model state
    logic         p_free, p_complete, p_mem_req, p_i_req, p_d_req, p_d_rd, p_d_wr;
    logic [27:0]  p_i_addr, p_d_addr, t_addr;
    logic [127:0] p_d_wdata, m_i_data, m_d_data, c_data;
    logic         m_last, m_side, i_done, d_done, c_now, e_side, e_rd, e_wr;
    logic [27:0]  e_addr;
    logic [1:0]   op;

    initial begin
        RESET = 1'b1; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0, 128'h0, {4{32'hDEADBEEF}}, 4,
                    1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0, 5};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h1234567, {4{32'hCAFEF00D}}, {4{32'h01234567}}, 0,
                    1'b1, 1'b1, 1'b0, 28'h1234567, {4{32'hCAFEF00D}}, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h7654321, {4{32'h89ABCDEF}}, {4{32'h5A5A5A5A}}, 2,
                    1'b1, 1'b0, 1'b1, 28'h7654321, {4{32'h89ABCDEF}}, 3};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h0ABCDEF, {16{8'h11}}, {4{32'h0F0F0F0F}}, 1,
                    1'b1, 1'b0, 1'b1, 28'h0ABCDEF, {16{8'h11}}, 2};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000AAA, 28'h0000BBB, 128'h0, {4{32'h600DCAFE}}, 3,
                    1'b1, 1'b1, 1'b0, 28'h0000BBB, 128'h0, 4};

        // Reset state
        do_reset();
        @(negedge CLK);
        check("reset mem ctrl", 128'({MEM_READ, MEM_WRITE}), 128'd0);
        check("reset mem addr", 128'(MEM_ADDRESS), 128'd0);
        check("reset mem wdata", MEM_WRITEDATA, 128'd0);
        check("reset readdata", I_READDATA | D_READDATA, 128'd0);
        check("reset busywait", 128'({I_BUSYWAIT, D_BUSYWAIT}), 128'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            dir_lat = vecs[v].lat; dir_data = vecs[v].mdata;
            I_READ = vecs[v].i_rd; I_ADDRESS = vecs[v].i_addr;
            D_READ = vecs[v].d_rd; D_WRITE = vecs[v].d_wr;
            D_ADDRESS = vecs[v].d_addr; D_WRITEDATA = vecs[v].d_wdata;
            @(negedge CLK);
            check($sformatf("v%0d idle cycle mem req", v), 128'(w_mem_req), 128'd0);
            ncyc = 0; done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge CLK);
                if (w_mem_req) begin
                    ncyc++;
                    check($sformatf("v%0d mem ctrl/addr", v), 128'({MEM_READ, MEM_WRITE, MEM_ADDRESS}),
                          128'({vecs[v].exp_rd, vecs[v].exp_wr, vecs[v].exp_addr}));
                    if (vecs[v].exp_d)
                        check($sformatf("v%0d mem wdata", v), MEM_WRITEDATA, vecs[v].exp_wdata);
                    check($sformatf("v%0d busy during grant", v),
                          128'(vecs[v].exp_d ? {D_BUSYWAIT, I_BUSYWAIT} : {I_BUSYWAIT, D_BUSYWAIT}),
                          128'({1'b1, vecs[v].exp_d ? vecs[v].i_rd : (vecs[v].d_rd | vecs[v].d_wr)}));
                end else begin
                    done = 1'b1;
                end
            end
            check($sformatf("v%0d grant cycles", v), 128'(ncyc), 128'(vecs[v].exp_cycles));
            check($sformatf("v%0d done-cycle busy", v),
                  128'(vecs[v].exp_d ? {D_BUSYWAIT, I_BUSYWAIT} : {I_BUSYWAIT, D_BUSYWAIT}),
                  128'({1'b0, vecs[v].exp_d ? vecs[v].i_rd : (vecs[v].d_rd | vecs[v].d_wr)}));
            check($sformatf("v%0d granted readdata", v),
                  vecs[v].exp_d ? D_READDATA : I_READDATA, vecs[v].mdata);
            check($sformatf("v%0d other readdata", v), vecs[v].exp_d ? I_READDATA : D_READDATA, 128'd0);
            @(posedge CLK); #1;
            I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
            @(negedge CLK);
            check($sformatf("v%0d back to idle", v), 128'(w_mem_req), 128'd0);
            check($sformatf("v%0d readdata held", v),
                  vecs[v].exp_d ? D_READDATA : I_READDATA, vecs[v].mdata);
        end

        // Both sides requesting continuously: D first, then alternate
        do_reset();
        dir_lat = 1; dir_data = {4{32'h13579BDF}};
        I_READ = 1'b1; I_ADDRESS = 28'h0000111; D_READ = 1'b1; D_ADDRESS = 28'h0000222;
        ng = 0; pm = 1'b0; dlow = 0; seen_i = 1'b0;
        for (int k = 0; k < 80 && ng < 4; k++) begin
            @(negedge CLK);
            if (!seen_i && !D_BUSYWAIT) dlow++;
            if (w_mem_req && !pm) begin
                side_d = (MEM_ADDRESS == 28'h0000222);
                check($sformatf("rr grant %0d side", ng), 128'(side_d), 128'(ng % 2 == 0));
                if (!side_d) seen_i = 1'b1;
                ng++;
            end
            pm = w_mem_req;
        end
        check("rr grant count", 128'(ng), 128'd4);
        check("rr D busywait low cycles before I grant", 128'(dlow), 128'd1);

        // Reset in the middle of a D grant
        do_reset();
        dir_lat = 5; dir_data = {4{32'hBADC0FFE}};
        D_READ = 1'b1; D_ADDRESS = 28'h0000333;
        @(negedge CLK);
        @(negedge CLK);
        check("mid-reset grant active", 128'(MEM_READ), 128'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; I_READ = 1'b1; I_ADDRESS = 28'h0000444;
        @(negedge CLK);
        check("mid-reset mem port cleared", 128'({MEM_READ, MEM_WRITE, MEM_ADDRESS}), 128'd0);
        check("mid-reset no DONE_D", 128'(D_BUSYWAIT), 128'd1);
        check("mid-reset D readdata", D_READDATA, 128'd0);
        @(negedge CLK);
        check("post-reset tie goes to D", 128'({MEM_READ, MEM_ADDRESS}), 128'({1'b1, 28'h0000333}));

        // Requester abandon
        do_reset();
        dir_lat = 0; dir_data = {4{32'hA5A5A5A5}};
        I_READ = 1'b1; I_ADDRESS = 28'h0000555;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        check("abandon setup readdata", I_READDATA, {4{32'hA5A5A5A5}});
        @(posedge CLK); #1;
        I_READ = 1'b0;
        dir_lat = 4; dir_data = {4{32'h77777777}};
        @(posedge CLK); #1;
        I_READ = 1'b1; I_ADDRESS = 28'h0000666;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        I_READ = 1'b0; I_ADDRESS = 28'h0000777; D_READ = 1'b1; D_ADDRESS = 28'h0000888;
        ncyc = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge CLK);
            if (w_mem_req) begin
                ncyc++;
                check("abandon addr held", 128'({MEM_READ, MEM_ADDRESS}), 128'({1'b1, 28'h0000666}));
                check("abandon D stalls", 128'(D_BUSYWAIT), 128'd1);
            end else begin
                done = 1'b1;
            end
        end
        check("abandon remaining grant cycles", 128'(ncyc), 128'd4);
        gap = 1;
        for (int k = 0; k < 10 && !w_mem_req; k++) begin
            @(negedge CLK);
            if (!w_mem_req) gap++;
            check("abandon I readdata unchanged", I_READDATA, {4{32'hA5A5A5A5}});
        end
        check("abandon idle gap before D grant", 128'(gap), 128'd1);
        check("abandon next grant is D", 128'(MEM_ADDRESS), 128'h0000888);

        // Random traffic against a transaction-level model
        do_reset();
        mem_rand = 1'b1;
        p_free = 1'b1; p_complete = 1'b0; p_mem_req = 1'b0; p_i_req = 1'b0; p_d_req = 1'b0;
        p_d_rd = 1'b0; p_d_wr = 1'b0; p_i_addr = '0; p_d_addr = '0; p_d_wdata = '0;
        m_i_data = '0; m_d_data = '0; m_last = LAST_I; m_side = 1'b0; t_addr = '0;
        i_done = 1'b0; d_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (i_done) I_READ = 1'b0;
            if (d_done) begin D_READ = 1'b0; D_WRITE = 1'b0; end
            if (!I_READ && $urandom_range(0, 3) == 0) begin
                I_READ = 1'b1; I_ADDRESS = 28'($urandom);
            end
            if (!(D_READ | D_WRITE) && $urandom_range(0, 3) == 0) begin
                op = 2'($urandom_range(1, 3));
                D_READ = op[0]; D_WRITE = op[1];
                D_ADDRESS = 28'($urandom);
                D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge CLK);
            check("rnd I readdata", I_READDATA, m_i_data);
            check("rnd D readdata", D_READDATA, m_d_data);
            check("rnd busywaits", 128'({I_BUSYWAIT, D_BUSYWAIT}),
                  128'({I_READ & ~(p_complete & ~m_side), (D_READ | D_WRITE) & ~(p_complete & m_side)}));
            if (p_free) check("rnd arbiter responsive", 128'(w_mem_req), 128'(p_i_req | p_d_req));
            if (w_mem_req && !p_mem_req) begin
                check("rnd start after free cycle", 128'(p_free), 128'd1);
                e_side = (p_i_req && p_d_req) ? ~m_last : p_d_req;
                e_addr = e_side ? p_d_addr : p_i_addr;
                e_rd   = e_side ? (p_d_rd & ~p_d_wr) : 1'b1;
                e_wr   = e_side ? p_d_wr : 1'b0;
                check("rnd grant addr/op", 128'({MEM_READ, MEM_WRITE, MEM_ADDRESS}), 128'({e_rd, e_wr, e_addr}));
                if (e_side) check("rnd grant wdata", MEM_WRITEDATA, p_d_wdata);
                m_last = e_side; m_side = e_side; t_addr = e_addr;
            end else if (w_mem_req) begin
                check("rnd addr stable", 128'(MEM_ADDRESS), 128'(t_addr));
            end
            c_now = w_mem_req && !MEM_BUSYWAIT;
            c_data = MEM_READDATA;
            if (c_now) begin
                if (m_side) m_d_data = c_data;
                else        m_i_data = c_data;
            end
            i_done = I_READ && !I_BUSYWAIT;
            d_done = (D_READ | D_WRITE) && !D_BUSYWAIT;
            p_free = !w_mem_req && !p_complete;
            p_complete = c_now; p_mem_req = w_mem_req;
            p_i_req = I_READ; p_i_addr = I_ADDRESS;
            p_d_req = D_READ | D_WRITE; p_d_rd = D_READ; p_d_wr = D_WRITE;
            p_d_addr = D_ADDRESS; p_d_wdata = D_WRITEDATA;
            @(posedge CLK); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port RESET, input, 1 bit: synchronous, active-high reset sampled on the CLK rising edge.
REQ-003 The block SHALL have the ports I_READ (input, 1) and I_ADDRESS (input, 28): instruction-cache block read request and block address.
REQ-004 The block SHALL have the ports I_READDATA (output, 128) and I_BUSYWAIT (output, 1): returned block and instruction-side stall.
REQ-005 The block SHALL have the ports D_READ (input, 1), D_WRITE (input, 1), D_ADDRESS (input, 28) and D_WRITEDATA (input, 128): data-cache fetch and write-back request.
REQ-006 The block SHALL have the ports D_READDATA (output, 128) and D_BUSYWAIT (output, 1): returned block and data-side stall.
REQ-007 The block SHALL have the ports MEM_READ (output, 1), MEM_WRITE (output, 1), MEM_ADDRESS (output, 28) and MEM_WRITEDATA (output, 128): the shared main-memory port.
REQ-008 The block SHALL have the ports MEM_READDATA (input, 128) and MEM_BUSYWAIT (input, 1): memory returns; MEM_BUSYWAIT=0 while a request is driven means complete, with data valid in that cycle.

Function
REQ-009 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D, DONE_I and DONE_D, and SHALL hold a 1-bit register LAST (last granted side).
REQ-010 In IDLE, with only I_READ high, the FSM SHALL move to GRANT_I.
REQ-011 In IDLE, with only D_READ or D_WRITE high, the FSM SHALL move to GRANT_D.
REQ-012 In IDLE, with both sides requesting, the FSM SHALL grant the side not equal to LAST (round-robin).
REQ-013 LAST SHALL update on entry to any GRANT state.
REQ-014 In GRANT_I the block SHALL drive MEM_READ=1, MEM_WRITE=0 and MEM_ADDRESS=I_ADDRESS.
REQ-015 In GRANT_D the block SHALL drive MEM_READ=D_READ&~D_WRITE, MEM_WRITE=D_WRITE, MEM_ADDRESS=D_ADDRESS and MEM_WRITEDATA=D_WRITEDATA; if D_READ and D_WRITE are both high, write wins.
REQ-016 In every other state MEM_READ and MEM_WRITE SHALL be 0, MEM_ADDRESS 0 and MEM_WRITEDATA 0.
REQ-017 In GRANT_x, a rising edge with MEM_BUSYWAIT=0 SHALL move the FSM to DONE_x and latch MEM_READDATA into the x-side read-data register.
REQ-018 Latency: minimum 3 cycles from request sampled in IDLE to the DONE cycle (IDLE, GRANT, DONE).
REQ-019 DONE_x SHALL last exactly one cycle, then return to IDLE.
REQ-020 I_BUSYWAIT SHALL equal I_READ & (state != DONE_I), combinationally.
REQ-021 D_BUSYWAIT SHALL equal (D_READ|D_WRITE) & (state != DONE_D), combinationally.
REQ-022 I_READDATA and D_READDATA SHALL be registered and hold their last latched value until overwritten.
REQ-023 A requester's request high in IDLE immediately after its own DONE SHALL be treated as a new request.
REQ-024 If the granted requester drops its request mid-GRANT, the transaction SHALL continue with the address latched at grant until the memory completes; the result SHALL be discarded and the FSM SHALL go to IDLE (not DONE).
REQ-025 To support REQ-024, the block SHALL register the granted address, write data and opcode on grant, and the memory port SHALL be driven from these registers.
REQ-026 A non-granted requester SHALL stall (busywait high) for the entire other transaction.

Reset
REQ-027 On RESET=1 at a CLK edge, the block SHALL set state=IDLE and LAST=I (so D wins the first tie).
REQ-028 On reset, the read-data registers SHALL clear to 0 and the latched address, data and opcode SHALL clear to 0.
REQ-029 From the first edge with RESET=1, all MEM_* outputs SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon it; no DONE cycle SHALL be produced.

Structure
REQ-031 A shared package SHALL hold the state encoding, ADDR_W=28, BLOCK_W=128 and the LAST encodings (I=0, D=1).
REQ-032 One sub-module, mem_arb_fsm (state register, LAST register, next-state logic), SHALL be used; the latches and steering SHALL sit in the top level.

Verification
REQ-033 Bench case, I-only read: I_READ=1, I_ADDRESS=0x0000010, memory completes after 4 busy cycles with 0xDEADBEEF_...; required: MEM_READ=1 for 5 cycles, I_BUSYWAIT drops in the DONE_I cycle, I_READDATA = that value.
REQ-034 Bench case, simultaneous first requests after reset: I_READ and D_READ both high; required: D granted first, then I, with D_BUSYWAIT low exactly one cycle before the I grant.
REQ-035 Bench case, round-robin: both sides continuously requesting for 4 transactions; required: grants D, I, D, I.
REQ-036 Bench case, write-back: D_WRITE=1, D_READ=1, D_ADDRESS=0x0ABCDEF, D_WRITEDATA=0x1111..; required: MEM_WRITE=1, MEM_READ=0 and address/data match until completion.
REQ-037 Bench case, reset mid-GRANT_D: RESET=1 for 1 cycle; required: MEM_READ and MEM_WRITE are 0 after that edge, state is IDLE, no DONE_D cycle, and the next tie goes to D.
REQ-038 Bench case, requester abandon: drop I_READ in the 2nd GRANT_I cycle; required: memory still sees the original address until complete, I_READDATA is unchanged, and the FSM returns to IDLE.
